// File: rtl/icb_arb_2m1s.sv
// Two-master to one-slave ICB arbiter: round-robin grant with lock while the
// slave stalls a command, and an ID FIFO that routes responses back in order.
module icb_arb_2m1s #(
  parameter int OUTS_DEPTH = 4,
  parameter int AW         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic                          m0_icb_cmd_valid,
  output logic                          m0_icb_cmd_ready,
  input  logic [AW-1:0]                 m0_icb_cmd_addr,
  input  logic                          m0_icb_cmd_read,
  input  logic [31:0]                   m0_icb_cmd_wdata,
  input  logic [3:0]                    m0_icb_cmd_wmask,
  output logic                          m0_icb_rsp_valid,
  input  logic                          m0_icb_rsp_ready,
  output logic                          m0_icb_rsp_err,
  output logic [31:0]                   m0_icb_rsp_rdata,

  input  logic                          m1_icb_cmd_valid,
  output logic                          m1_icb_cmd_ready,
  input  logic [AW-1:0]                 m1_icb_cmd_addr,
  input  logic                          m1_icb_cmd_read,
  input  logic [31:0]                   m1_icb_cmd_wdata,
  input  logic [3:0]                    m1_icb_cmd_wmask,
  output logic                          m1_icb_rsp_valid,
  input  logic                          m1_icb_rsp_ready,
  output logic                          m1_icb_rsp_err,
  output logic [31:0]                   m1_icb_rsp_rdata,

  output logic                          s_icb_cmd_valid,
  input  logic                          s_icb_cmd_ready,
  output logic [AW-1:0]                 s_icb_cmd_addr,
  output logic                          s_icb_cmd_read,
  output logic [31:0]                   s_icb_cmd_wdata,
  output logic [3:0]                    s_icb_cmd_wmask,
  input  logic                          s_icb_rsp_valid,
  output logic                          s_icb_rsp_ready,
  input  logic                          s_icb_rsp_err,
  input  logic [31:0]                   s_icb_rsp_rdata,

  output logic [$clog2(OUTS_DEPTH):0]   outs_cnt,
  output logic                          proto_err
);

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH) + 1;

  logic          r_last_id, r_lock, r_lock_id, r_proto_err;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_fifo [OUTS_DEPTH];

  logic w_gnt, w_full, w_empty, w_head, w_cmd_vld, w_push, w_pop, w_rsp_rdy;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Lock wins over round-robin so a stalled slave command never changes source.
  always_comb begin
    w_gnt = 1'b0;
    if (r_lock)                                      w_gnt = r_lock_id;
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid)   w_gnt = ~r_last_id;
    else if (m1_icb_cmd_valid)                       w_gnt = 1'b1;
  end

  assign w_full    = (r_cnt == CW'(OUTS_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_head    = r_fifo[r_rptr];
  assign w_cmd_vld = (m0_icb_cmd_valid | m1_icb_cmd_valid) & ~w_full;
  assign w_push    = w_cmd_vld & s_icb_cmd_ready;

  assign s_icb_cmd_valid  = w_cmd_vld;
  assign s_icb_cmd_addr   = w_gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_read   = w_gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_wdata  = w_gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask  = w_gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  assign m0_icb_cmd_ready = ~w_gnt & s_icb_cmd_ready & ~w_full;
  assign m1_icb_cmd_ready =  w_gnt & s_icb_cmd_ready & ~w_full;

  // With nothing outstanding a slave response has no owner: swallow it.
  assign w_rsp_rdy = w_empty ? s_icb_rsp_valid
                             : (w_head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign w_pop     = s_icb_rsp_valid & w_rsp_rdy & ~w_empty;

  assign s_icb_rsp_ready  = w_rsp_rdy;
  assign m0_icb_rsp_valid = s_icb_rsp_valid & ~w_empty & ~w_head;
  assign m1_icb_rsp_valid = s_icb_rsp_valid & ~w_empty &  w_head;
  assign m0_icb_rsp_err   = s_icb_rsp_err;
  assign m1_icb_rsp_err   = s_icb_rsp_err;
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

  assign outs_cnt  = r_cnt;
  assign proto_err = r_proto_err;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_id   <= 1'b1;
      r_lock      <= 1'b0;
      r_lock_id   <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_last_id <= w_gnt;
        r_lock    <= 1'b0;
        r_wptr    <= f_inc(r_wptr);
      end else if (w_cmd_vld) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_gnt;
      end
      if (w_pop) r_rptr <= f_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (s_icb_rsp_valid && w_empty) r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icb_arb_2m1s.sv
// Directed bench for icb_arb_2m1s: one process drives masters and a slave
// model per cycle, a negedge monitor scores cmd order and response routing.
module tb_icb_arb_2m1s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_rsp_rdata;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_rsp_rdata;
  logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [31:0] s_icb_rsp_rdata;
  logic [2:0]  outs_cnt;
  logic        proto_err;

  icb_arb_2m1s #(.OUTS_DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata),
    .outs_cnt(outs_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic id; logic [31:0] addr; } cmd_t;
  typedef struct { logic id; logic [31:0] rdata; logic err; } rsp_t;

  cmd_t        exp_cmd[$];
  rsp_t        exp_rsp[$];
  logic [31:0] m0_q[$], m1_q[$], pend[$];
  logic        rsp_en, spur, err_f;
  int          n_tests = 0, n_fail = 0;
  int          peak;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  cmd_t mc;
  rsp_t mr;

  task automatic chk_rsp(input logic id, input logic [31:0] rd, input logic er);
    if (exp_rsp.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_unexpected: got response at m%0d expected none", id);
    end else begin
      mr = exp_rsp.pop_front();
      chk("rsp_id", {31'd0, id}, {31'd0, mr.id});
      chk("rsp_rdata", rd, mr.rdata);
      chk("rsp_err", {31'd0, er}, {31'd0, mr.err});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rsp_onehot", {31'd0, m0_icb_rsp_valid & m1_icb_rsp_valid}, 32'd0);
      if (s_icb_cmd_valid && s_icb_cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cmd_unexpected: got addr %h expected none", s_icb_cmd_addr);
        end else begin
          mc = exp_cmd.pop_front();
          chk("cmd_addr", s_icb_cmd_addr, mc.addr);
          chk("cmd_wdata", s_icb_cmd_wdata, ~mc.addr);
          chk("cmd_wmask", {28'd0, s_icb_cmd_wmask}, mc.id ? 32'h3 : 32'hF);
          chk("cmd_read", {31'd0, s_icb_cmd_read}, 32'd1);
        end
      end
      if (m0_icb_rsp_valid && m0_icb_rsp_ready) chk_rsp(1'b0, m0_icb_rsp_rdata, m0_icb_rsp_err);
      if (m1_icb_rsp_valid && m1_icb_rsp_ready) chk_rsp(1'b1, m1_icb_rsp_rdata, m1_icb_rsp_err);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive();
    m0_icb_cmd_valid = (m0_q.size() > 0);
    m0_icb_cmd_addr  = m0_icb_cmd_valid ? m0_q[0] : 32'd0;
    m0_icb_cmd_wdata = ~m0_icb_cmd_addr;
    m1_icb_cmd_valid = (m1_q.size() > 0);
    m1_icb_cmd_addr  = m1_icb_cmd_valid ? m1_q[0] : 32'd0;
    m1_icb_cmd_wdata = ~m1_icb_cmd_addr;
    // slave answers one cycle or more after acceptance, rdata = addr + 0x1000_0000
    s_icb_rsp_valid  = spur | (rsp_en & (pend.size() > 0));
    s_icb_rsp_rdata  = (pend.size() > 0) ? pend[0] + 32'h1000_0000 : 32'd0;
    s_icb_rsp_err    = err_f;
  endtask

  // One clock: sample handshakes late in the cycle, update drives after the edge.
  task automatic tick();
    logic h0, h1, hs, hr;
    logic [31:0] sa;
    @(negedge clk);
    h0 = rst_n & m0_icb_cmd_valid & m0_icb_cmd_ready;
    h1 = rst_n & m1_icb_cmd_valid & m1_icb_cmd_ready;
    hs = rst_n & s_icb_cmd_valid & s_icb_cmd_ready;
    hr = rst_n & s_icb_rsp_valid & s_icb_rsp_ready;
    sa = s_icb_cmd_addr;
    @(posedge clk);
    #1;
    if (h0 && m0_q.size() > 0) void'(m0_q.pop_front());
    if (h1 && m1_q.size() > 0) void'(m1_q.pop_front());
    if (hr && pend.size() > 0) void'(pend.pop_front());
    if (hs) pend.push_back(sa);
    drive();
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] rd, input logic er);
    cmd_t c;
    rsp_t r;
    if (id) m1_q.push_back(a); else m0_q.push_back(a);
    c.id = id; c.addr = a;
    r.id = id; r.rdata = rd; r.err = er;
    exp_cmd.push_back(c);
    exp_rsp.push_back(r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_q.delete(); m1_q.delete(); pend.delete();
    exp_cmd.delete(); exp_rsp.delete();
    s_icb_cmd_ready = 1'b0; rsp_en = 1'b0; spur = 1'b0; err_f = 1'b0;
    m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    peak = 0;
    for (int i = 0; i < 200 && (exp_cmd.size() + exp_rsp.size()) > 0; i++) begin
      tick();
      #3;
      if (int'(outs_cnt) > peak) peak = int'(outs_cnt);
    end
    chk({nm, "_drained"}, exp_cmd.size() + exp_rsp.size(), 32'd0);
  endtask

  initial begin
    m0_icb_cmd_read = 1'b1; m0_icb_cmd_wmask = 4'hF;
    m1_icb_cmd_read = 1'b1; m1_icb_cmd_wmask = 4'h3;
    do_reset();

    // reset state
    #3;
    chk("rst_m0_cmd_ready", {31'd0, m0_icb_cmd_ready}, 0);
    chk("rst_m1_cmd_ready", {31'd0, m1_icb_cmd_ready}, 0);
    chk("rst_s_cmd_valid",  {31'd0, s_icb_cmd_valid}, 0);
    chk("rst_m0_rsp_valid", {31'd0, m0_icb_rsp_valid}, 0);
    chk("rst_m1_rsp_valid", {31'd0, m1_icb_rsp_valid}, 0);
    chk("rst_s_rsp_ready",  {31'd0, s_icb_rsp_ready}, 0);
    chk("rst_outs_cnt",     {29'd0, outs_cnt}, 0);
    chk("rst_proto_err",    {31'd0, proto_err}, 0);

    // single master m1, three reads, 1-cycle slave
    s_icb_cmd_ready = 1'b1; rsp_en = 1'b1;
    issue(1'b1, 32'h2000_0000, 32'h3000_0000, 1'b0);
    issue(1'b1, 32'h2000_0004, 32'h3000_0004, 1'b0);
    issue(1'b1, 32'h2000_0008, 32'h3000_0008, 1'b0);
    wait_idle("single");
    chk("single_peak_cnt", peak, 1);

    // contention: strict alternation starting with m0
    do_reset();
    s_icb_cmd_ready = 1'b1; rsp_en = 1'b1;
    issue(1'b0, 32'h0000_0100, 32'h1000_0100, 1'b0);
    issue(1'b1, 32'h0000_0200, 32'h1000_0200, 1'b0);
    issue(1'b0, 32'h0000_0104, 32'h1000_0104, 1'b0);
    issue(1'b1, 32'h0000_0204, 32'h1000_0204, 1'b0);
    issue(1'b0, 32'h0000_0108, 32'h1000_0108, 1'b0);
    issue(1'b1, 32'h0000_0208, 32'h1000_0208, 1'b0);
    wait_idle("contend");

    // lock: m1 stalled by slave while m0 raises valid
    do_reset();
    rsp_en = 1'b1;
    issue(1'b1, 32'h0000_0300, 32'h1000_0300, 1'b0);
    tick();
    issue(1'b0, 32'h0000_0400, 32'h1000_0400, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("lock_addr", s_icb_cmd_addr, 32'h0000_0300);
      chk("lock_m0_ready", {31'd0, m0_icb_cmd_ready}, 0);
      tick();
    end
    s_icb_cmd_ready = 1'b1;
    wait_idle("lock");

    // full: 5 commands, slave withholds responses
    do_reset();
    s_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      issue(1'b0, 32'h0000_0500 + 32'(4 * i), 32'h1000_0500 + 32'(4 * i), 1'b0);
    repeat (7) tick();
    #3;
    chk("full_cnt", {29'd0, outs_cnt}, 4);
    chk("full_m0_ready", {31'd0, m0_icb_cmd_ready}, 0);
    chk("full_s_valid", {31'd0, s_icb_cmd_valid}, 0);
    chk("full_accepted", exp_cmd.size(), 1);
    rsp_en = 1'b1;
    tick();
    #3;
    chk("full_pop_cycle_s_valid", {31'd0, s_icb_cmd_valid}, 0);
    chk("full_pop_cycle_rsp_ready", {31'd0, s_icb_rsp_ready}, 1);
    tick();
    #3;
    chk("full_reopen_s_valid", {31'd0, s_icb_cmd_valid}, 1);
    chk("full_reopen_m0_ready", {31'd0, m0_icb_cmd_ready}, 1);
    wait_idle("full");

    // backpressure with error response
    do_reset();
    s_icb_cmd_ready = 1'b1;
    issue(1'b0, 32'h0000_0600, 32'h1000_0600, 1'b1);
    repeat (3) tick();
    err_f = 1'b1; m0_icb_rsp_ready = 1'b0; rsp_en = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("bp_m0_rsp_valid", {31'd0, m0_icb_rsp_valid}, 1);
      chk("bp_s_rsp_ready", {31'd0, s_icb_rsp_ready}, 0);
      chk("bp_cnt", {29'd0, outs_cnt}, 1);
      tick();
    end
    m0_icb_rsp_ready = 1'b1;
    tick();
    #3;
    chk("bp_cnt_after", {29'd0, outs_cnt}, 0);
    chk("bp_rsp_consumed", exp_rsp.size(), 0);
    chk("bp_proto_err", {31'd0, proto_err}, 0);
    err_f = 1'b0;

    // spurious response, then async reset mid-burst
    do_reset();
    spur = 1'b1;
    tick();
    #3;
    chk("spur_s_rsp_ready", {31'd0, s_icb_rsp_ready}, 1);
    chk("spur_m0_rsp_valid", {31'd0, m0_icb_rsp_valid}, 0);
    chk("spur_m1_rsp_valid", {31'd0, m1_icb_rsp_valid}, 0);
    spur = 1'b0;
    tick();
    #3;
    chk("spur_proto_err", {31'd0, proto_err}, 1);
    s_icb_cmd_ready = 1'b1;
    issue(1'b0, 32'h0000_0700, 32'h1000_0700, 1'b0);
    issue(1'b0, 32'h0000_0704, 32'h1000_0704, 1'b0);
    issue(1'b0, 32'h0000_0708, 32'h1000_0708, 1'b0);
    repeat (3) tick();
    #3;
    chk("burst_cnt", {29'd0, outs_cnt}, 2);
    chk("proto_err_sticky", {31'd0, proto_err}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", {29'd0, outs_cnt}, 0);
    chk("async_rst_proto_err", {31'd0, proto_err}, 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icb_arb_2m1s.md
# icb_arb_2m1s

Two-master to one-slave ICB arbiter with round-robin grant, grant locking and in-order response routing. It sits between the JTAG debug master (m0) and the core data master (m1) and a single shared ICB slave, such as sram or sys_perip, when that slave is used without the full crossbar. Commands pass through combinationally. A small ID FIFO records which master owns each outstanding command, so that every response returns to its originator.

## Interface
Parameters:
- OUTS_DEPTH, default 4: maximum outstanding commands. Must be a power of two, 1..8.
- AW, default 32: ICB address width.

Ports (x = 0, 1 for the masters; s = slave side):
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mx_icb_cmd_valid  in  1  master x command valid
- mx_icb_cmd_ready  out  1  master x command accepted
- mx_icb_cmd_addr  in  AW  master x address
- mx_icb_cmd_read  in  1  1 = read, 0 = write
- mx_icb_cmd_wdata  in  32  write data
- mx_icb_cmd_wmask  in  4  byte write mask
- mx_icb_rsp_valid  out  1  response valid to master x
- mx_icb_rsp_ready  in  1  master x accepts response
- mx_icb_rsp_err  out  1  response error
- mx_icb_rsp_rdata  out  32  read data
- s_icb_cmd_valid / s_icb_cmd_addr / s_icb_cmd_read / s_icb_cmd_wdata / s_icb_cmd_wmask  out  1/AW/1/32/4  command to slave
- s_icb_cmd_ready  in  1  slave accepts command
- s_icb_rsp_valid / s_icb_rsp_err / s_icb_rsp_rdata  in  1/1/32  slave response
- s_icb_rsp_ready  out  1  arbiter accepts response
- outs_cnt  out  $clog2(OUTS_DEPTH)+1  current outstanding count
- proto_err  out  1  sticky: a slave response arrived while no command was outstanding

## Operation
- Grant selection:
  - Only m0 valid → grant m0. Only m1 valid → grant m1.
  - Both valid → grant the master that is not last_id (round-robin).
  - last_id updates to the granted ID on each cmd handshake (s_icb_cmd_valid & s_icb_cmd_ready).
- Grant lock: if s_icb_cmd_valid=1 and s_icb_cmd_ready=0, set lock=1 and lock_id=granted ID. While lock=1 the grant is forced to lock_id. Lock clears on the next cmd handshake. The slave-side command is therefore never switched mid-handshake.
- Command path:
  - full = (outs_cnt == OUTS_DEPTH).
  - s_icb_cmd_valid = (m0_valid | m1_valid) & ~full.
  - The slave cmd fields are muxed from the granted master.
  - Granted mx_icb_cmd_ready = s_icb_cmd_ready & ~full. The non-granted master's ready = 0.
- ID FIFO: OUTS_DEPTH entries of 1 bit.
  - Push the granted ID on cmd handshake.
  - Pop on rsp handshake.
  - Push and pop in the same cycle are both allowed: count unchanged, pointers wrap modulo OUTS_DEPTH.
- Response path:
  - Head ID h selects the target.
  - mh_icb_rsp_valid = s_icb_rsp_valid & ~empty. The other master's rsp_valid = 0.
  - s_icb_rsp_ready = mh_icb_rsp_ready when not empty.
  - err and rdata are broadcast to both masters; only the valid master samples them.
- Empty with s_icb_rsp_valid=1: s_icb_rsp_ready=1 (response dropped), proto_err set. proto_err clears only on reset.
- Reset mid-operation clears the FIFO, lock and outstanding count. In-flight responses are subsequently treated as protocol errors.

## Timing
- Reset values:
  - All mx_icb_cmd_ready, mx_icb_rsp_valid and s_icb_cmd_valid = 0. s_icb_rsp_ready = 0.
  - outs_cnt = 0, proto_err = 0, lock = 0.
  - last_id = 1, so m0 wins the first tie.
- Command latency: 0 cycles (combinational pass-through, no registers in the cmd path).
- Response latency: 0 cycles. The head ID is registered and stable before the response arrives.
- outs_cnt updates on the clk edge after the handshake: +1 push only, −1 pop only, unchanged for both or neither.
- A response in the same cycle as the command that produced it (slave with zero-cycle rsp) is illegal. The slave must respond at least 1 cycle after cmd handshake.
- When full, a pop in cycle N reopens the cmd path in cycle N+1, not combinationally.

## Test plan
- Single master: m1 issues 3 reads to 0x2000_0000/4/8 with slave cmd_ready=1 and 1-cycle rsp → 3 responses arrive at m1 in order with the matching rdata; m0 never sees rsp_valid; outs_cnt peaks at 1.
- Contention: m0 and m1 hold valid continuously for 6 handshakes → grant order m0,m1,m0,m1,m0,m1; responses routed per the pushed ID.
- Lock: m1 granted, slave holds cmd_ready=0 for 3 cycles while m0 raises valid → s_icb_cmd_addr stays at m1's address all 3 cycles; m0 is granted on the cycle after m1's handshake.
- Full: OUTS_DEPTH=4, slave withholds rsp, m0 issues 5 commands → 4 accepted, 5th cmd_ready=0 with outs_cnt=4; one rsp handshake → 5th accepted the next cycle.
- Backpressure and error: m0 rsp_ready=0 for 2 cycles with s_icb_rsp_err=1 → s_icb_rsp_ready=0 for those cycles; m0 receives err=1 once ready rises; FIFO pops exactly once.
- Spurious response: s_icb_rsp_valid=1 with FIFO empty → dropped, proto_err=1 until rst_n is asserted low; async reset mid-burst → outs_cnt=0 immediately.
